branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 16, the number of 2-bit predictor counters (power of 2).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port FetchPC  in  32  PC currently being fetched, used for the predictor lookup.
REQ-005 SHALL have port PredTaken  out  1  predicted direction for FetchPC.
REQ-006 SHALL have port ExValid  in  1  the EX stage holds a valid instruction.
REQ-007 SHALL have port ExStall  in  1  EX is held this cycle, so no resolution takes place.
REQ-008 SHALL have ports ExIsBranch / ExIsJal / ExIsJalr  in  1 each  instruction class in EX.
REQ-009 SHALL have ports ExPC, ExImm, ExRs1  in  32 each  PC, sign-extended immediate and forwarded rs1 of the EX instruction.
REQ-010 SHALL have port BranchTaken  in  1  condition result from the branch comparator in EX.
REQ-011 SHALL have port ExPredTaken  in  1  prediction carried down the pipe with the EX instruction.
REQ-012 SHALL have port Redirect  out  1  the fetch PC must be replaced with RedirectPC.
REQ-013 SHALL have port RedirectPC  out  32  corrected fetch PC.
REQ-014 SHALL have ports FlushIFID / FlushIDEX  out  1 each  bubble the named pipeline register on the next edge.
REQ-015 SHALL have port MisalignErr  out  1  the resolved target is not word-aligned.
REQ-016 SHALL have port MispredCount  out  32  performance counter.

Function
REQ-017 SHALL resolve only when Resolve = ExValid & ~ExStall & (state == IDLE) & rst_n; when Resolve is 0, all combinational outputs are 0.
REQ-018 SHALL give class priority JALR > JAL > Branch when more than one class flag is set.
REQ-019 SHALL compute Taken = Jal | Jalr | (Branch & BranchTaken).
REQ-020 SHALL compute Target as (ExRs1 + ExImm) & ~1 for JALR and ExPC + ExImm otherwise; Fallthrough = ExPC + 4; all sums are 32-bit and wrap modulo 2^32.
REQ-021 SHALL raise Mispredict for every jump, and for a branch when Taken != ExPredTaken.
REQ-022 SHALL set RedirectPC = Taken ? Target : Fallthrough, and Redirect = FlushIFID = FlushIDEX = Mispredict, all in the resolving cycle (0-cycle latency).
REQ-023 SHALL, when Taken and Target[1:0] != 0, assert MisalignErr, force Redirect to 0, keep both flushes at 1 and skip the predictor update.
REQ-024 SHALL implement an FSM with states IDLE and SHADOW: IDLE->SHADOW on any Redirect or MisalignErr; SHADOW->IDLE on the next cycle with ExStall = 0; SHADOW holds while ExStall = 1; no resolution, update or counting occurs in SHADOW.
REQ-025 SHALL index the predictor with PC[log2(BHT_ENTRIES)+1:2]; PredTaken = counter[FetchPC index][1], combinational.
REQ-026 SHALL, on a resolved branch (not jump), update counter[ExPC index] at the edge: Taken -> saturating increment to 2'b11, else saturating decrement to 2'b00.
REQ-027 SHALL return the pre-update value on a same-cycle lookup and update of the same index.
REQ-028 SHALL increment MispredCount on each Redirect or MisalignErr, saturating at 32'hFFFFFFFF.

Reset
REQ-029 SHALL, while rst_n = 0 (asynchronous), set state = IDLE, all counters = 2'b01, MispredCount = 0, and hold PredTaken and all EX-side outputs at 0.
REQ-030 SHALL, on an rst_n assertion mid-SHADOW, return to IDLE with no pending update.

Structure
REQ-031 SHALL take the FSM state enum, counter encodings (SNT = 00, WNT = 01, WT = 10, ST = 11) and BHT_IDX_W from the shared package pipeline_pkg.
REQ-032 SHALL place the predictor table in one sub-module, bht_2bit (async read, sync write, async reset).

Verification
REQ-033 SHALL cover: BEQ at ExPC = 0x100, ExImm = 0x40, BranchTaken = 1, ExPredTaken = 0 -> Redirect = 1, RedirectPC = 0x140, both flushes = 1, MispredCount = 1, counter[0] 01->10.
REQ-034 SHALL cover: the same branch with ExPredTaken = 1 and BranchTaken = 1 -> Redirect = 0, counter 10->11; repeated taken keeps it at 11.
REQ-035 SHALL cover: JALR with ExRs1 = 0x2001, ExImm = 0x3 -> RedirectPC = 0x2004; the next cycle is SHADOW, and an ExValid JAL presented there produces no redirect.
REQ-036 SHALL cover: JAL with ExPC = 0x100, ExImm = 0x2 -> MisalignErr = 1, Redirect = 0, flushes = 1, no BHT change.
REQ-037 SHALL cover: ExPC = 0xFFFFFFFC, not taken, ExPredTaken = 1 -> RedirectPC = 0x00000000 (wrap).
REQ-038 SHALL cover: rst_n pulsed low mid-SHADOW with counters trained -> state IDLE, all counters 01, MispredCount 0, outputs 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg -- shared types and constants for the fetch/execute pipeline.
//   bru_state_t : branch resolve unit FSM state (IDLE / SHADOW)
//   bht_ctr_t   : 2-bit saturating predictor counter encoding
//   BHT_IDX_W   : default predictor index width (16 entries)
//   ctr_next()  : saturating counter update toward taken / not-taken
package pipeline_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SHADOW = 1'b1
  } bru_state_t;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_t;

  localparam int unsigned BHT_IDX_W = 4;

  function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
    bht_ctr_t n;
    n = c;
    if (taken) begin
      if (c != ST) n = bht_ctr_t'(c + 2'd1);
    end else begin
      if (c != SNT) n = bht_ctr_t'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// bht_2bit -- table of 2-bit saturating branch predictor counters.
//   clk, rst_n : clock, asynchronous active-low reset (all entries -> WNT)
//   rd_idx     : lookup index; rd_ctr is the combinational counter value
//   wr_en      : update the entry at wr_idx on the rising edge
//   wr_taken   : update direction (saturating increment when 1, decrement when 0)
// A read and write of the same index in one cycle returns the pre-update value.
module bht_2bit
  import pipeline_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_ctr_t tbl [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl[i] <= WNT;
    end else if (wr_en) begin
      tbl[wr_idx] <= ctr_next(tbl[wr_idx], wr_taken);
    end
  end

  assign rd_ctr = tbl[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit -- resolves branches/jumps in EX, redirects fetch on a
// misprediction and trains a 2-bit direction predictor.
//   clk, rst_n          : clock, asynchronous active-low reset
//   FetchPC / PredTaken : predictor lookup for the fetch stage
//   ExValid, ExStall    : EX occupancy and hold
//   ExIsBranch/Jal/Jalr : instruction class (JALR > JAL > Branch)
//   ExPC, ExImm, ExRs1  : operands for target computation
//   BranchTaken         : comparator result; ExPredTaken: carried prediction
//   Redirect/RedirectPC : fetch correction; FlushIFID/FlushIDEX: bubbles
//   MisalignErr         : taken target not word aligned
//   MispredCount        : saturating count of redirects and misalign errors
// After any redirect or misalign error the unit spends one SHADOW cycle
// (extended while ExStall is high) ignoring the wrong-path EX instruction.
module branch_resolve_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 2 ** BHT_IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] FetchPC,
  output logic        PredTaken,
  input  logic        ExValid,
  input  logic        ExStall,
  input  logic        ExIsBranch,
  input  logic        ExIsJal,
  input  logic        ExIsJalr,
  input  logic [31:0] ExPC,
  input  logic [31:0] ExImm,
  input  logic [31:0] ExRs1,
  input  logic        BranchTaken,
  input  logic        ExPredTaken,
  output logic        Redirect,
  output logic [31:0] RedirectPC,
  output logic        FlushIFID,
  output logic        FlushIDEX,
  output logic        MisalignErr,
  output logic [31:0] MispredCount
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  bru_state_t  state, state_nxt;
  bht_ctr_t    fetch_ctr;
  logic        resolve, is_jalr, is_jal, is_br;
  logic        taken, mispred, misalign, bht_we;
  logic [31:0] jalr_sum, target, fallthru;
  logic        unused_fetch_bits;

  assign unused_fetch_bits = ^{FetchPC[31:IDX_W+2], FetchPC[1:0]};

  always_comb begin
    resolve  = ExValid & ~ExStall & (state == IDLE) & rst_n;
    is_jalr  = ExIsJalr;
    is_jal   = ExIsJal & ~ExIsJalr;
    is_br    = ExIsBranch & ~ExIsJal & ~ExIsJalr;
    jalr_sum = ExRs1 + ExImm;
    target   = is_jalr ? {jalr_sum[31:1], 1'b0} : (ExPC + ExImm);
    fallthru = ExPC + 32'd4;
    taken    = is_jal | is_jalr | (is_br & BranchTaken);
    // Jumps are never predicted, so every resolved jump redirects.
    mispred  = is_jal | is_jalr | (is_br & (taken ^ ExPredTaken));
    misalign = taken & (target[1:0] != 2'b00);

    // A misaligned target suppresses the redirect but still flushes the
    // wrong-path instructions, even for a correctly predicted branch.
    Redirect    = resolve & mispred & ~misalign;
    MisalignErr = resolve & misalign;
    FlushIFID   = resolve & (mispred | misalign);
    FlushIDEX   = resolve & (mispred | misalign);
    RedirectPC  = resolve ? (taken ? target : fallthru) : '0;
    bht_we      = resolve & is_br & ~misalign;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Redirect | MisalignErr) state_nxt = SHADOW;
      SHADOW:  if (!ExStall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      MispredCount <= '0;
    end else begin
      state <= state_nxt;
      if ((Redirect | MisalignErr) && (MispredCount != '1))
        MispredCount <= MispredCount + 32'd1;
    end
  end

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (FetchPC[IDX_W+1:2]),
    .rd_ctr   (fetch_ctr),
    .wr_en    (bht_we),
    .wr_idx   (ExPC[IDX_W+1:2]),
    .wr_taken (taken)
  );

  assign PredTaken = rst_n & fetch_ctr[1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int unsigned N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] FetchPC;
  logic        PredTaken;
  logic        ExValid, ExStall, ExIsBranch, ExIsJal, ExIsJalr;
  logic [31:0] ExPC, ExImm, ExRs1;
  logic        BranchTaken, ExPredTaken;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        FlushIFID, FlushIDEX, MisalignErr;
  logic [31:0] MispredCount;

  always #5 clk = ~clk;

  branch_resolve_unit #(.BHT_ENTRIES(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .FetchPC      (FetchPC),
    .PredTaken    (PredTaken),
    .ExValid      (ExValid),
    .ExStall      (ExStall),
    .ExIsBranch   (ExIsBranch),
    .ExIsJal      (ExIsJal),
    .ExIsJalr     (ExIsJalr),
    .ExPC         (ExPC),
    .ExImm        (ExImm),
    .ExRs1        (ExRs1),
    .BranchTaken  (BranchTaken),
    .ExPredTaken  (ExPredTaken),
    .Redirect     (Redirect),
    .RedirectPC   (RedirectPC),
    .FlushIFID    (FlushIFID),
    .FlushIDEX    (FlushIDEX),
    .MisalignErr  (MisalignErr),
    .MispredCount (MispredCount)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: predictor counters as integers 0..3, a miss counter and
  // a "skip the next EX instruction" flag.
  int          m_ctr [N];
  logic [31:0] m_cnt;
  bit          m_shadow;
  bit          p_upd, p_taken, p_event, p_leave;
  int          p_idx;

  initial begin
    for (int i = 0; i < N; i++) m_ctr[i] = 1;
    m_cnt = '0; m_shadow = 0;
    p_upd = 0; p_taken = 0; p_event = 0; p_leave = 0; p_idx = 0;
  end

  always @(negedge clk) begin : compare
    logic        e_red, e_fl, e_mis, e_pred, res, tk, jump, br, bad;
    logic [31:0] e_rpc, tgt, sum;
    e_red = 0; e_fl = 0; e_mis = 0; e_pred = 0; e_rpc = '0;
    tk = 0; jump = 0; br = 0; bad = 0; tgt = '0;
    p_upd = 0; p_event = 0; p_leave = 0;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_ctr[i] = 1;
      m_cnt = '0;
      m_shadow = 0;
    end else begin
      res    = ExValid && !ExStall && !m_shadow;
      e_pred = (m_ctr[int'((FetchPC >> 2) % N)] >= 2);
      p_leave = m_shadow && !ExStall;
      if (res) begin
        if (ExIsJalr) begin
          sum = ExRs1 + ExImm;
          tgt = (sum >> 1) << 1;
          tk = 1; jump = 1;
        end else if (ExIsJal) begin
          tgt = ExPC + ExImm; tk = 1; jump = 1;
        end else if (ExIsBranch) begin
          tgt = ExPC + ExImm; tk = BranchTaken; br = 1;
        end
        bad   = tk && ((tgt % 4) != 0);
        e_rpc = tk ? tgt : ExPC + 32'd4;
        e_red = (jump || (br && (tk != ExPredTaken))) && !bad;
        e_fl  = jump || (br && (tk != ExPredTaken)) || bad;
        e_mis = bad;
        p_upd   = br && !bad;
        p_idx   = int'((ExPC >> 2) % N);
        p_taken = tk;
        p_event = e_red || bad;
      end
    end
    chk1("Redirect", Redirect, e_red);
    chk ("RedirectPC", RedirectPC, e_rpc);
    chk1("FlushIFID", FlushIFID, e_fl);
    chk1("FlushIDEX", FlushIDEX, e_fl);
    chk1("MisalignErr", MisalignErr, e_mis);
    chk1("PredTaken", PredTaken, e_pred);
    chk ("MispredCount", MispredCount, m_cnt);
  end

  always @(posedge clk) begin : model_step
    if (rst_n) begin
      if (p_upd) begin
        if (p_taken) m_ctr[p_idx] = (m_ctr[p_idx] == 3) ? 3 : m_ctr[p_idx] + 1;
        else         m_ctr[p_idx] = (m_ctr[p_idx] == 0) ? 0 : m_ctr[p_idx] - 1;
      end
      if (p_event) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        m_shadow = 1;
      end else if (p_leave) begin
        m_shadow = 0;
      end
    end
    p_upd = 0; p_event = 0; p_leave = 0;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic [31:0] fpc);
    ExValid = 0; ExStall = 0; ExIsBranch = 0; ExIsJal = 0; ExIsJalr = 0;
    BranchTaken = 0; ExPredTaken = 0; FetchPC = fpc;
  endtask

  task automatic ex(input logic v, input logic st, input logic b, input logic j,
                    input logic jr, input logic bt, input logic pt,
                    input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
    ExValid = v; ExStall = st; ExIsBranch = b; ExIsJal = j; ExIsJalr = jr;
    BranchTaken = bt; ExPredTaken = pt;
    ExPC = pc; ExImm = imm; ExRs1 = rs1; FetchPC = pc;
  endtask

  initial begin
    rst_n = 0;
    idle(32'h0);
    ExPC = '0; ExImm = '0; ExRs1 = '0;
    cyc(); cyc(); mid();
    chk ("reset MispredCount", MispredCount, 32'h0);
    chk1("reset PredTaken", PredTaken, 1'b0);
    chk1("reset Redirect", Redirect, 1'b0);
    cyc(); rst_n = 1;

    // Mispredicted taken BEQ
    ex(1,0,1,0,0,1,0, 32'h100, 32'h40, 32'h0); mid();
    chk1("beq Redirect", Redirect, 1'b1);
    chk ("beq RedirectPC", RedirectPC, 32'h140);
    chk1("beq FlushIFID", FlushIFID, 1'b1);
    chk1("beq FlushIDEX", FlushIDEX, 1'b1);
    chk1("beq PredTaken pre", PredTaken, 1'b0);
    cyc(); idle(32'h100); mid();
    chk ("beq count", MispredCount, 32'd1);
    chk1("beq ctr 10", PredTaken, 1'b1);

    // Correctly predicted taken, twice (10->11->11), then not taken (11->10)
    cyc(); ex(1,0,1,0,0,1,1, 32'h100, 32'h40, 32'h0); mid();
    chk1("pred ok Redirect", Redirect, 1'b0);
    chk1("pred ok Flush", FlushIFID, 1'b0);
    cyc(); ex(1,0,1,0,0,1,1, 32'h100, 32'h40, 32'h0); mid();
    chk1("pred ok2 Redirect", Redirect, 1'b0);
    cyc(); ex(1,0,1,0,0,0,1, 32'h100, 32'h40, 32'h0); mid();
    chk1("nt Redirect", Redirect, 1'b1);
    chk ("nt RedirectPC", RedirectPC, 32'h104);
    cyc(); idle(32'h100); mid();
    chk1("sat ctr 10", PredTaken, 1'b1);
    chk ("nt count", MispredCount, 32'd2);

    // JALR, then a JAL in the shadow cycle
    cyc(); ex(1,0,0,0,1,0,0, 32'h200, 32'h3, 32'h2001); mid();
    chk1("jalr Redirect", Redirect, 1'b1);
    chk ("jalr RedirectPC", RedirectPC, 32'h2004);
    cyc(); ex(1,0,0,1,0,0,0, 32'h300, 32'h10, 32'h0); mid();
    chk1("shadow Redirect", Redirect, 1'b0);
    chk ("shadow RedirectPC", RedirectPC, 32'h0);
    chk1("shadow FlushIDEX", FlushIDEX, 1'b0);

    // Class priority
    cyc(); ex(1,0,1,1,1,1,1, 32'h40, 32'h20, 32'h1000); mid();
    chk ("prio jalr RedirectPC", RedirectPC, 32'h1020);
    cyc(); idle(32'h0);
    cyc(); ex(1,0,1,1,0,0,0, 32'h80, 32'h8, 32'h0); mid();
    chk ("prio jal RedirectPC", RedirectPC, 32'h88);
    chk1("prio jal Redirect", Redirect, 1'b1);
    cyc(); idle(32'h100);

    // Misaligned JAL, then SHADOW held by stall
    cyc(); ex(1,0,0,1,0,0,0, 32'h100, 32'h2, 32'h0); mid();
    chk1("mis MisalignErr", MisalignErr, 1'b1);
    chk1("mis Redirect", Redirect, 1'b0);
    chk1("mis FlushIFID", FlushIFID, 1'b1);
    chk1("mis FlushIDEX", FlushIDEX, 1'b1);
    cyc(); ex(1,1,0,1,0,0,0, 32'h100, 32'h10, 32'h0);
    cyc();
    cyc(); ex(1,0,0,1,0,0,0, 32'h100, 32'h10, 32'h0); mid();
    chk1("held shadow Redirect", Redirect, 1'b0);
    cyc(); mid();
    chk1("after shadow Redirect", Redirect, 1'b1);
    chk ("after shadow RedirectPC", RedirectPC, 32'h110);
    cyc(); idle(32'h100);

    // Misaligned predicted-taken branch: flush, no redirect, no training
    cyc(); ex(1,0,1,0,0,1,1, 32'h100, 32'h6, 32'h0); mid();
    chk1("mis br MisalignErr", MisalignErr, 1'b1);
    chk1("mis br FlushIFID", FlushIFID, 1'b1);
    chk1("mis br Redirect", Redirect, 1'b0);
    cyc(); idle(32'h100);
    cyc(); ex(1,0,1,0,0,0,1, 32'h100, 32'h40, 32'h0); mid();
    chk1("nt2 Redirect", Redirect, 1'b1);
    cyc(); idle(32'h100); mid();
    chk1("no train ctr 01", PredTaken, 1'b0);
    chk ("count 9", MispredCount, 32'd9);

    // Fallthrough wrap
    cyc(); ex(1,0,1,0,0,0,1, 32'hFFFF_FFFC, 32'h8, 32'h0); mid();
    chk ("wrap RedirectPC", RedirectPC, 32'h0);
    chk1("wrap Redirect", Redirect, 1'b1);
    cyc(); idle(32'h0);

    // Non-control instruction
    cyc(); ex(1,0,0,0,0,0,0, 32'h500, 32'h4, 32'h0); mid();
    chk1("alu Redirect", Redirect, 1'b0);
    chk ("alu RedirectPC", RedirectPC, 32'h504);

    // Train idx 3, enter SHADOW, reset mid-SHADOW
    cyc(); ex(1,0,1,0,0,1,1, 32'hC, 32'h10, 32'h0);
    cyc();
    cyc(); idle(32'hC); mid();
    chk1("trained ctr", PredTaken, 1'b1);
    cyc(); ex(1,0,0,1,0,0,0, 32'hC, 32'h20, 32'h0);
    cyc(); ex(1,1,0,1,0,0,0, 32'hC, 32'h20, 32'h0); rst_n = 0; mid();
    chk ("rst count", MispredCount, 32'h0);
    chk1("rst PredTaken", PredTaken, 1'b0);
    chk1("rst Redirect", Redirect, 1'b0);
    chk ("rst RedirectPC", RedirectPC, 32'h0);
    chk1("rst FlushIFID", FlushIFID, 1'b0);
    cyc(); idle(32'h0);
    cyc(); rst_n = 1;
    for (int unsigned i = 0; i < N; i++) begin
      cyc(); FetchPC = 32'(i * 4); mid();
      chk1("rst ctr 01", PredTaken, 1'b0);
    end
    cyc(); ex(1,0,1,0,0,1,0, 32'hC, 32'h10, 32'h0); mid();
    chk1("post rst idle Redirect", Redirect, 1'b1);
    cyc(); idle(32'hC); mid();
    chk ("post rst count", MispredCount, 32'd1);
    chk1("post rst ctr 10", PredTaken, 1'b1);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
